// File: rtl/spi_master_phy.sv
// spi_master_phy -- SPI master bit-level PHY.
//
// Runs one SPI transaction of bit_total bits: a SETUP half-period with cs_n
// low, bit_total SCLK periods (low half then high half), and a HOLD
// half-period, followed by a one-cycle done pulse back in IDLE.
// MOSI bits are pulled from an upstream serializer one at a time. Each take
// is signalled by a can_ref_new_data pulse.
//
// Parameters:
//   HALF_DIV  system clocks per SCLK half-period (1..255)
//   CPOL      SCLK idle level
// Ports:
//   clock, rst_n           system clock, asynchronous active-low reset
//   start, bit_total       transaction request and its length (latched on accept)
//   tx_data, tx_valid      upstream serial bit, consumed when can_ref_new_data=1
//   miso                   serial data from the slave
//   can_ref_new_data       one-cycle take pulse toward the upstream stage
//   trigger_cnt            bit periods started in the current transaction
//   idle, done             FSM in IDLE / end-of-transaction pulse
//   sclk, cs_n, mosi       SPI pins, registered
//   rx_bit, rx_bit_valid   sampled MISO bit and its strobe
//   fsm_state              current FSM state, for observation
//
// Handshake: the upstream stage keeps tx_data/tx_valid stable while
// can_ref_new_data is high. The PHY consumes them on that clock edge and
// never stalls. tx_valid=0 at a take sends a 0 bit.
//
// Build option: define SPI_PHY_MISO_EN to enable MISO sampling. When it is not
// defined, rx_bit and rx_bit_valid are tied to 0.
module spi_master_phy #(
  parameter int HALF_DIV = 4,
  parameter bit CPOL     = 1'b0
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] bit_total,
  input  logic        tx_data,
  input  logic        tx_valid,
  input  logic        miso,
  output logic        can_ref_new_data,
  output logic [23:0] trigger_cnt,
  output logic        idle,
  output logic        done,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  output logic        rx_bit,
  output logic        rx_bit_valid,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  localparam logic [7:0] LAST = 8'(HALF_DIV - 1);

  state_t      state, nxt_state;
  logic [7:0]  cnt, nxt_cnt;
  logic        phase, nxt_phase;      // 0 = low half, 1 = high half of a bit
  logic [23:0] total, nxt_total;
  logic [23:0] nxt_trig;
  logic        nxt_take;
  logic        half_tick;
  logic        rise;                  // internal SCLK rises on the coming edge

  assign fsm_state = state;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 8'd1;
    nxt_phase = phase;
    nxt_total = total;
    nxt_trig  = trigger_cnt + {23'd0, can_ref_new_data};
    half_tick = (cnt == LAST);
    case (state)
      IDLE: begin
        nxt_cnt = 8'd0;
        if (start && (bit_total != 24'd0)) begin
          nxt_state = SETUP;
          nxt_total = bit_total;
          nxt_trig  = 24'd0;
          nxt_phase = 1'b0;
        end
      end
      SETUP: begin
        if (half_tick) begin
          nxt_state = SHIFT;
          nxt_cnt   = 8'd0;
          nxt_phase = 1'b0;
        end
      end
      SHIFT: begin
        if (half_tick) begin
          nxt_cnt = 8'd0;
          if (!phase)                   nxt_phase = 1'b1;
          else if (trigger_cnt == total) nxt_state = HOLD;
          else                          nxt_phase = 1'b0;
        end
      end
      HOLD: begin
        if (half_tick) begin
          nxt_state = IDLE;
          nxt_cnt   = 8'd0;
        end
      end
      default: nxt_state = IDLE;
    endcase
    // Take pulse is registered, so it is decided one cycle ahead, from the
    // state/counter values of the cycle it will be visible in.
    nxt_take = ((nxt_state == SETUP) && (nxt_cnt == LAST)) ||
               ((nxt_state == SHIFT) && nxt_phase && (nxt_cnt == LAST) &&
                (nxt_trig != nxt_total));
    rise = (state == SHIFT) && !phase && half_tick;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= 8'd0;
      phase            <= 1'b0;
      total            <= 24'd0;
      trigger_cnt      <= 24'd0;
      can_ref_new_data <= 1'b0;
      idle             <= 1'b1;
      done             <= 1'b0;
      cs_n             <= 1'b1;
      sclk             <= CPOL;
      mosi             <= 1'b0;
    end else begin
      state            <= nxt_state;
      cnt              <= nxt_cnt;
      phase            <= nxt_phase;
      total            <= nxt_total;
      trigger_cnt      <= nxt_trig;
      can_ref_new_data <= nxt_take;
      idle             <= (nxt_state == IDLE);
      done             <= (state == HOLD) && (nxt_state == IDLE);
      cs_n             <= (nxt_state == IDLE);
      sclk             <= ((nxt_state == SHIFT) && nxt_phase) ^ CPOL;
      if (can_ref_new_data)
        mosi <= tx_valid ? tx_data : 1'b0;
      else if (nxt_state != SHIFT)
        mosi <= 1'b0;
    end
  end

`ifdef SPI_PHY_MISO_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_bit       <= 1'b0;
      rx_bit_valid <= 1'b0;
    end else begin
      rx_bit_valid <= rise;
      if (rise) rx_bit <= miso;
    end
  end
`else
  // miso is folded into a constant-zero term so the input still has a reader.
  assign rx_bit       = miso & 1'b0;
  assign rx_bit_valid = rise & 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_phy.sv
// tb_spi_master_phy -- self-checking bench for spi_master_phy.
// Transactions are described as bit arrays. Expected pin behaviour is derived
// from the transaction rules: mosi at each SCLK rise, cs_n low for
// 2*H*(n+1) cycles, n take pulses, trigger_cnt = n, and one done pulse.
module tb_spi_master_phy;
  localparam int H  = 2;
  localparam bit CP = 1'b1;

  logic        clock, rst_n, start, tx_data, tx_valid, miso;
  logic [23:0] bit_total;
  logic        can_ref_new_data, idle, done, sclk, cs_n, mosi, rx_bit, rx_bit_valid;
  logic [23:0] trigger_cnt;
  logic [1:0]  fsm_state;

  spi_master_phy #(.HALF_DIV(H), .CPOL(CP)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .bit_total(bit_total),
    .tx_data(tx_data), .tx_valid(tx_valid), .miso(miso),
    .can_ref_new_data(can_ref_new_data), .trigger_cnt(trigger_cnt),
    .idle(idle), .done(done), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .rx_bit(rx_bit), .rx_bit_valid(rx_bit_valid), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // transaction description: bit i is the i-th bit on the wire
  logic bits [24];
  logic vals [24];
  logic mp   [24];
  logic [0:0] exp_q[$];
  logic [0:0] rx_q[$];

  task automatic fill_byte(input logic [7:0] d, input logic [7:0] v, input logic [7:0] m);
    for (int i = 0; i < 8; i++) begin
      bits[i] = d[7-i];
      vals[i] = v[7-i];
      mp[i]   = m[7-i];
    end
  endtask

  // Runs one transaction of n bits and checks it. If chain is set, start is
  // raised again on the done cycle with bit_total = next_n.
  task automatic run_txn(input int n, input bit skip_start, input int mid_start_at,
                         input bit chain, input int next_n);
    int cs_low, takes, rises, rx_seen, cyc, idx, budget;
    bit prev_ref, prev_s, got_done;
    cs_low = 0; takes = 0; rises = 0; rx_seen = 0; cyc = 0;
    prev_ref = 0; prev_s = 0; got_done = 0;
    budget = 2 * H * (n + 1) + 20;
    exp_q.delete(); rx_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(vals[i] ? bits[i] : 1'b0);
      rx_q.push_back(mp[i]);
    end
    if (!skip_start) begin
      start = 1'b1;
      bit_total = 24'(n);
    end
    tx_data = bits[0]; tx_valid = vals[0]; miso = 1'b0;
    while (!got_done && cyc < budget) begin
      @(posedge clock); #1;
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        check("enter_cs_n", {31'd0, cs_n}, 32'd0);
        check("enter_idle", {31'd0, idle}, 32'd0);
      end
      if (!cs_n) cs_low++;
      if (prev_ref) takes++;
      prev_ref = can_ref_new_data;
      if ((sclk ^ CP) && !prev_s) begin
        rises++;
        if (exp_q.size() > 0) check("mosi_bit", {31'd0, mosi}, {31'd0, exp_q.pop_front()});
      end
      prev_s = sclk ^ CP;
      if (rx_bit_valid) begin
        rx_seen++;
        if (rx_q.size() > 0) check("rx_bit", {31'd0, rx_bit}, {31'd0, rx_q.pop_front()});
      end
      idx = (takes < 24) ? takes : 23;
      tx_data  = bits[idx];
      tx_valid = vals[idx];
      miso     = (takes > 0) ? mp[idx > 0 ? idx - 1 : 0] : 1'b0;
      if (cyc == mid_start_at) begin
        start = 1'b1;
        bit_total = 24'(n + 3);
      end
      if (done) begin
        got_done = 1'b1;
        check("done_idle", {31'd0, idle}, 32'd1);
        check("done_cs_n", {31'd0, cs_n}, 32'd1);
        check("trigger_cnt_final", {8'd0, trigger_cnt}, 32'(n));
        if (chain) begin
          start = 1'b1;
          bit_total = 24'(next_n);
        end
      end
    end
    check("done_seen", {31'd0, got_done}, 32'd1);
    check("cs_low_cycles", 32'(cs_low), 32'(2 * H * (n + 1)));
    check("take_pulses", 32'(takes), 32'(n));
    check("sclk_rises", 32'(rises), 32'(n));
`ifdef SPI_PHY_MISO_EN
    check("rx_strobes", 32'(rx_seen), 32'(n));
`else
    check("rx_strobes", 32'(rx_seen), 32'd0);
`endif
    if (!chain) begin
      @(posedge clock); #1;
      check("trigger_cnt_hold", {8'd0, trigger_cnt}, 32'(n));
    end
  endtask

  // start with bit_total=0 must leave the PHY untouched
  task automatic zero_start;
    int low_cnt, ref_cnt, busy_cnt, edge_cnt;
    low_cnt = 0; ref_cnt = 0; busy_cnt = 0; edge_cnt = 0;
    start = 1'b1; bit_total = 24'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (!cs_n) low_cnt++;
      if (can_ref_new_data) ref_cnt++;
      if (!idle) busy_cnt++;
      if (sclk !== CP) edge_cnt++;
    end
    check("zero_cs_low", 32'(low_cnt), 32'd0);
    check("zero_takes", 32'(ref_cnt), 32'd0);
    check("zero_busy", 32'(busy_cnt), 32'd0);
    check("zero_sclk", 32'(edge_cnt), 32'd0);
  endtask

  initial begin
    logic [7:0] d8, v8, m8;
    int n, mid;
    rst_n = 1'b0; start = 1'b0; bit_total = 24'd0;
    tx_data = 1'b0; tx_valid = 1'b0; miso = 1'b0;
    for (int i = 0; i < 24; i++) begin bits[i] = 0; vals[i] = 0; mp[i] = 0; end
    repeat (3) @(posedge clock);
    #1;
    check("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_sclk", {31'd0, sclk}, {31'd0, CP});
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_trig", {8'd0, trigger_cnt}, 32'd0);
    check("rst_ref_done", {30'd0, can_ref_new_data, done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("post_rst_idle", {31'd0, cs_n & idle}, 32'd1);

    // 0xA5, all valid, miso 0x3C
    d8 = 8'hA5; v8 = 8'hFF; m8 = 8'h3C;
    fill_byte(d8, v8, m8);
    run_txn(8, 1'b0, 0, 1'b0, 0);

    zero_start();

    // tx_valid low for bits 4-8
    d8 = 8'hFF; v8 = 8'hE0; m8 = 8'h96;
    fill_byte(d8, v8, m8);
    run_txn(8, 1'b0, 0, 1'b0, 0);

    // repeated start mid-transaction, then start on the done cycle
    d8 = 8'h5A; v8 = 8'hFF; m8 = 8'hC3;
    fill_byte(d8, v8, m8);
    run_txn(8, 1'b0, 9, 1'b1, 5);
    d8 = 8'hB8; v8 = 8'hF8; m8 = 8'h48;
    fill_byte(d8, v8, m8);
    run_txn(5, 1'b1, 0, 1'b0, 0);

    // randomized transactions
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < 24; i++) begin
        bits[i] = 1'($urandom_range(0, 1));
        vals[i] = ($urandom_range(0, 3) != 0);
        mp[i]   = 1'($urandom_range(0, 1));
      end
      mid = ($urandom_range(0, 1) != 0) ? $urandom_range(2, 2 * H * (n + 1) - 1) : 0;
      run_txn(n, 1'b0, mid, 1'b0, 0);
    end

    // reset during SHIFT
    d8 = 8'hA5; v8 = 8'hFF; m8 = 8'h00;
    fill_byte(d8, v8, m8);
    start = 1'b1; bit_total = 24'd8;
    tx_data = bits[0]; tx_valid = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_cs_n", {31'd0, cs_n}, 32'd1);
    check("midrst_sclk", {31'd0, sclk}, {31'd0, CP});
    check("midrst_trig", {8'd0, trigger_cnt}, 32'd0);
    check("midrst_idle_mosi", {30'd0, idle, mosi}, 32'd2);
    @(posedge clock); #3;
    rst_n = 1'b1;
    begin
      int low_cnt;
      low_cnt = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clock); #1;
        if (!cs_n || (sclk !== CP)) low_cnt++;
      end
      check("post_midrst_quiet", 32'(low_cnt), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
